backend_cmd_arbiter: RTL and testbench

BACKEND_CMD_ARBITER -- requirements
Module: backend_cmd_arbiter

---
 rtl/backend_cmd_arbiter.sv | 174 +++++++++++++++++
 tb/tb_backend_cmd_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backend_cmd_arbiter.sv
// Two-requester round-robin arbiter for the ORAM backend. It forwards one command
// and then routes a full block of store or load beats for the granted requester.
module backend_cmd_arbiter #(
  parameter int ORAMU    = 32,
  parameter int ORAML    = 10,
  parameter int ORAMB    = 512,
  parameter int FEDWidth = 32
) (
  input  logic                Clock,
  input  logic                Reset,

  input  logic                Req0CmdValid,
  output logic                Req0CmdReady,
  input  logic [1:0]          Req0Cmd,
  input  logic [ORAMU-1:0]    Req0Addr,
  input  logic [ORAML-1:0]    Req0OldLeaf,
  input  logic [ORAML-1:0]    Req0NewLeaf,
  input  logic                Req0StoreValid,
  output logic                Req0StoreReady,
  input  logic [FEDWidth-1:0] Req0StoreData,
  output logic                Req0LoadValid,
  input  logic                Req0LoadReady,
  output logic [FEDWidth-1:0] Req0LoadData,

  input  logic                Req1CmdValid,
  output logic                Req1CmdReady,
  input  logic [1:0]          Req1Cmd,
  input  logic [ORAMU-1:0]    Req1Addr,
  input  logic [ORAML-1:0]    Req1OldLeaf,
  input  logic [ORAML-1:0]    Req1NewLeaf,
  input  logic                Req1StoreValid,
  output logic                Req1StoreReady,
  input  logic [FEDWidth-1:0] Req1StoreData,
  output logic                Req1LoadValid,
  input  logic                Req1LoadReady,
  output logic [FEDWidth-1:0] Req1LoadData,

  output logic                CmdOutValid,
  input  logic                CmdOutReady,
  output logic [1:0]          CmdOut,
  output logic [ORAMU-1:0]    AddrOut,
  output logic [ORAML-1:0]    OldLeaf,
  output logic [ORAML-1:0]    NewLeaf,

  output logic                StoreDataValid,
  input  logic                StoreDataReady,
  output logic [FEDWidth-1:0] StoreData,

  input  logic                LoadDataValid,
  output logic                LoadDataReady,
  input  logic [FEDWidth-1:0] LoadData,

  output logic                Owner,
  output logic                Busy,
  output logic                ProtocolError
);

  localparam int Chunks = ORAMB / FEDWidth;
  localparam int BeatW  = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Chunks - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCmd   = 2'd1,
    StStore = 2'd2,
    StLoad  = 2'd3
  } state_t;

  state_t              state;
  logic [BeatW-1:0]    beatCnt;
  logic                lastGrant;
  logic                ownerReg;
  logic                protoErrReg;
  logic [1:0]          cmdReg;
  logic [ORAMU-1:0]    addrReg;
  logic [ORAML-1:0]    oldLeafReg;
  logic [ORAML-1:0]    newLeafReg;

  logic                live;
  logic                grantAny;
  logic                grantSel;
  logic                inStore;
  logic                inLoad;
  logic                ownerStoreValid;
  logic                ownerLoadReady;
  logic                beatFire;

  // Every handshake output is held low while Reset is asserted.
  assign live = Reset;

  // Round-robin: on a tie the requester not granted last time wins.
  assign grantAny = live && (state == StIdle) && (Req0CmdValid || Req1CmdValid);
  assign grantSel = (Req0CmdValid && Req1CmdValid) ? ~lastGrant : Req1CmdValid;

  assign Req0CmdReady = grantAny && !grantSel;
  assign Req1CmdReady = grantAny && grantSel;

  assign CmdOutValid = live && (state == StCmd);
  assign CmdOut      = cmdReg;
  assign AddrOut     = addrReg;
  assign OldLeaf     = oldLeafReg;
  assign NewLeaf     = newLeafReg;

  assign inStore         = live && (state == StStore);
  assign inLoad          = live && (state == StLoad);
  assign ownerStoreValid = ownerReg ? Req1StoreValid : Req0StoreValid;
  assign ownerLoadReady  = ownerReg ? Req1LoadReady  : Req0LoadReady;

  assign StoreDataValid = inStore && ownerStoreValid;
  assign StoreData      = ownerReg ? Req1StoreData : Req0StoreData;
  assign Req0StoreReady = inStore && !ownerReg && StoreDataReady;
  assign Req1StoreReady = inStore &&  ownerReg && StoreDataReady;

  assign LoadDataReady = inLoad && ownerLoadReady;
  assign Req0LoadValid = inLoad && !ownerReg && LoadDataValid;
  assign Req1LoadValid = inLoad &&  ownerReg && LoadDataValid;
  assign Req0LoadData  = LoadData;
  assign Req1LoadData  = LoadData;

  assign beatFire = (StoreDataValid && StoreDataReady) || (inLoad && LoadDataValid && ownerLoadReady);

  assign Owner         = ownerReg;
  assign Busy          = (state != StIdle);
  assign ProtocolError = protoErrReg;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= StIdle;
      beatCnt     <= '0;
      lastGrant   <= 1'b1;
      ownerReg    <= 1'b0;
      protoErrReg <= 1'b0;
      cmdReg      <= '0;
      addrReg     <= '0;
      oldLeafReg  <= '0;
      newLeafReg  <= '0;
    end else begin
      // A load beat arriving when nothing is being read is dropped but remembered.
      if (LoadDataValid && (state != StLoad))
        protoErrReg <= 1'b1;

      case (state)
        StIdle: begin
          if (grantAny) begin
            cmdReg     <= grantSel ? Req1Cmd     : Req0Cmd;
            addrReg    <= grantSel ? Req1Addr    : Req0Addr;
            oldLeafReg <= grantSel ? Req1OldLeaf : Req0OldLeaf;
            newLeafReg <= grantSel ? Req1NewLeaf : Req0NewLeaf;
            ownerReg   <= grantSel;
            lastGrant  <= grantSel;
            state      <= StCmd;
          end
        end
        StCmd: begin
          // Read and ReadRmv both have the upper command bit set.
          if (CmdOutReady)
            state <= cmdReg[1] ? StLoad : StStore;
        end
        StStore, StLoad: begin
          if (beatFire) begin
            if (beatCnt == LastBeat) begin
              beatCnt <= '0;
              state   <= StIdle;
            end else begin
              beatCnt <= beatCnt + BeatW'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_backend_cmd_arbiter.sv
// Scenario bench for backend_cmd_arbiter: expected commands and beats are queued
// as stimulus is driven and compared as the arbiter forwards them.
module tb_backend_cmd_arbiter;

  localparam int ORAMU    = 32;
  localparam int ORAML    = 10;
  localparam int ORAMB    = 512;
  localparam int FEDWidth = 32;
  localparam int Chunks   = ORAMB / FEDWidth;
  localparam int FW       = 2 + ORAMU + 2 * ORAML;

  logic                Clock = 1'b0;
  logic                Reset = 1'b0;
  logic                Req0CmdValid = 1'b0, Req1CmdValid = 1'b0;
  logic                Req0CmdReady, Req1CmdReady;
  logic [1:0]          Req0Cmd = '0, Req1Cmd = '0;
  logic [ORAMU-1:0]    Req0Addr = '0, Req1Addr = '0;
  logic [ORAML-1:0]    Req0OldLeaf = '0, Req1OldLeaf = '0;
  logic [ORAML-1:0]    Req0NewLeaf = '0, Req1NewLeaf = '0;
  logic                Req0StoreValid = 1'b0, Req1StoreValid = 1'b0;
  logic                Req0StoreReady, Req1StoreReady;
  logic [FEDWidth-1:0] Req0StoreData = '0, Req1StoreData = '0;
  logic                Req0LoadValid, Req1LoadValid;
  logic                Req0LoadReady = 1'b0, Req1LoadReady = 1'b0;
  logic [FEDWidth-1:0] Req0LoadData, Req1LoadData;
  logic                CmdOutValid;
  logic                CmdOutReady = 1'b0;
  logic [1:0]          CmdOut;
  logic [ORAMU-1:0]    AddrOut;
  logic [ORAML-1:0]    OldLeaf, NewLeaf;
  logic                StoreDataValid;
  logic                StoreDataReady = 1'b0;
  logic [FEDWidth-1:0] StoreData;
  logic                LoadDataValid = 1'b0;
  logic                LoadDataReady;
  logic [FEDWidth-1:0] LoadData = '0;
  logic                Owner, Busy, ProtocolError;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0]       cmdQ[$];
  logic [FEDWidth-1:0] dataQ[$];

  always #5 Clock = ~Clock;

  backend_cmd_arbiter #(
    .ORAMU(ORAMU), .ORAML(ORAML), .ORAMB(ORAMB), .FEDWidth(FEDWidth)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0CmdValid(Req0CmdValid), .Req0CmdReady(Req0CmdReady), .Req0Cmd(Req0Cmd),
    .Req0Addr(Req0Addr), .Req0OldLeaf(Req0OldLeaf), .Req0NewLeaf(Req0NewLeaf),
    .Req0StoreValid(Req0StoreValid), .Req0StoreReady(Req0StoreReady), .Req0StoreData(Req0StoreData),
    .Req0LoadValid(Req0LoadValid), .Req0LoadReady(Req0LoadReady), .Req0LoadData(Req0LoadData),
    .Req1CmdValid(Req1CmdValid), .Req1CmdReady(Req1CmdReady), .Req1Cmd(Req1Cmd),
    .Req1Addr(Req1Addr), .Req1OldLeaf(Req1OldLeaf), .Req1NewLeaf(Req1NewLeaf),
    .Req1StoreValid(Req1StoreValid), .Req1StoreReady(Req1StoreReady), .Req1StoreData(Req1StoreData),
    .Req1LoadValid(Req1LoadValid), .Req1LoadReady(Req1LoadReady), .Req1LoadData(Req1LoadData),
    .CmdOutValid(CmdOutValid), .CmdOutReady(CmdOutReady), .CmdOut(CmdOut),
    .AddrOut(AddrOut), .OldLeaf(OldLeaf), .NewLeaf(NewLeaf),
    .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady), .StoreData(StoreData),
    .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady), .LoadData(LoadData),
    .Owner(Owner), .Busy(Busy), .ProtocolError(ProtocolError)
  );

  // Inputs change 1 time unit after a rising edge; outputs are read on the falling edge.
  task automatic set_req(input int n, input logic v, input logic [1:0] c,
                         input logic [ORAMU-1:0] a, input logic [ORAML-1:0] o,
                         input logic [ORAML-1:0] w);
    if (n == 0) begin
      Req0CmdValid = v; Req0Cmd = c; Req0Addr = a; Req0OldLeaf = o; Req0NewLeaf = w;
    end else begin
      Req1CmdValid = v; Req1Cmd = c; Req1Addr = a; Req1OldLeaf = o; Req1NewLeaf = w;
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    Req0CmdValid = 1'b0; Req1CmdValid = 1'b0;
    CmdOutReady = 1'b0; StoreDataReady = 1'b0; LoadDataValid = 1'b0;
    Req0StoreValid = 1'b0; Req1StoreValid = 1'b0;
    Req0LoadReady = 1'b0; Req1LoadReady = 1'b0;
    cmdQ.delete();
    dataQ.delete();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic run_op(input int req, input logic [1:0] cmd, input logic [ORAMU-1:0] addr,
                        input logic [ORAML-1:0] oldL, input logic [ORAML-1:0] newL,
                        input int cmdStall, input bit throttle, input bit drop,
                        input logic [FEDWidth-1:0] base, input string tag);
    bit got, done, isStore;
    logic rdy, oRdy, xRdy, oVld, xVld;
    logic [FEDWidth-1:0] oDat, xDat, ed;
    logic [FW-1:0] exp;
    int stall, beats, pushed, occ, winner;
    isStore = (cmd < 2'd2);
    set_req(req, 1'b1, cmd, addr, oldL, newL);
    cmdQ.push_back({cmd, addr, oldL, newL});
    got = 1'b0; occ = 0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge Clock);
      if (Req0CmdReady === 1'b1 || Req1CmdReady === 1'b1) begin
        got = 1'b1; occ = 1;
        winner = (Req1CmdReady === 1'b1) ? 1 : 0;
        checks++;
        if ((Req0CmdReady === 1'b1 && Req1CmdReady === 1'b1) || winner != req) begin
          errors++;
          $display("FAIL %s grant: ready0=%b ready1=%b, required winner %0d", tag, Req0CmdReady, Req1CmdReady, req);
        end
        checks++;
        if (CmdOutValid !== 1'b0) begin
          errors++;
          $display("FAIL %s latency: CmdOutValid=%b in grant cycle, required 0", tag, CmdOutValid);
        end
      end
      @(posedge Clock); #1;
      if (got && drop) begin
        if (req == 0) Req0CmdValid = 1'b0; else Req1CmdValid = 1'b0;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s grant-timeout: no CmdReady within 40 cycles, required grant to %0d", tag, req);
      cmdQ.delete();
      return;
    end

    // command phase
    stall = 0; done = 1'b0;
    CmdOutReady = (cmdStall == 0);
    for (int cyc = 0; cyc < cmdStall + 10 && !done; cyc++) begin
      @(negedge Clock); occ++;
      exp = cmdQ[0];
      checks++;
      if ({CmdOutValid, CmdOut, AddrOut, OldLeaf, NewLeaf} !== {1'b1, exp} || Owner !== 1'(req)) begin
        errors++;
        $display("FAIL %s cmd: got valid=%b fields=%h owner=%b, required valid=1 fields=%h owner=%0d",
                 tag, CmdOutValid, {CmdOut, AddrOut, OldLeaf, NewLeaf}, Owner, exp, req);
      end
      checks++;
      if ({Req0CmdReady, Req1CmdReady, Busy} !== 3'b001) begin
        errors++;
        $display("FAIL %s cmd-state: ready0/ready1/busy=%b, required 001", tag, {Req0CmdReady, Req1CmdReady, Busy});
      end
      if (CmdOutValid === 1'b1 && CmdOutReady) begin
        void'(cmdQ.pop_front());
        done = 1'b1;
      end
      @(posedge Clock); #1;
      stall++;
      CmdOutReady = (stall >= cmdStall);
    end
    CmdOutReady = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s cmd-timeout: no CmdOut handshake, required one after %0d stall cycles", tag, cmdStall);
      return;
    end

    // data phase
    beats = 0; pushed = 0;
    for (int cyc = 0; cyc < 200 && beats < Chunks; cyc++) begin
      ed = base + 32'(beats);
      if (pushed == beats) begin
        dataQ.push_back(ed);
        pushed++;
      end
      rdy = throttle ? ((cyc % 2) == 0) : 1'b1;
      if (isStore) begin
        if (req == 1) begin Req1StoreValid = 1'b1; Req1StoreData = ed; end
        else begin Req0StoreValid = 1'b1; Req0StoreData = ed; end
        StoreDataReady = rdy;
      end else begin
        LoadDataValid = 1'b1; LoadData = ed;
        if (req == 1) begin Req1LoadReady = rdy; Req0LoadReady = 1'b1; end
        else begin Req0LoadReady = rdy; Req1LoadReady = 1'b1; end
      end
      @(negedge Clock); occ++;
      if (isStore) begin
        oRdy = (req == 1) ? Req1StoreReady : Req0StoreReady;
        xRdy = (req == 1) ? Req0StoreReady : Req1StoreReady;
        checks++;
        if (StoreDataValid !== 1'b1 || StoreData !== dataQ[0]) begin
          errors++;
          $display("FAIL %s store-data beat %0d: got valid=%b data=%h, required valid=1 data=%h",
                   tag, beats, StoreDataValid, StoreData, dataQ[0]);
        end
        checks++;
        if ({oRdy, xRdy, LoadDataReady} !== {rdy, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s store-ready: owner/other/loadrdy=%b, required %b", tag, {oRdy, xRdy, LoadDataReady}, {rdy, 2'b00});
        end
        if (StoreDataValid === 1'b1 && StoreDataReady) begin
          void'(dataQ.pop_front());
          beats++;
        end
      end else begin
        oVld = (req == 1) ? Req1LoadValid : Req0LoadValid;
        xVld = (req == 1) ? Req0LoadValid : Req1LoadValid;
        oDat = (req == 1) ? Req1LoadData : Req0LoadData;
        xDat = (req == 1) ? Req0LoadData : Req1LoadData;
        checks++;
        if (oVld !== 1'b1 || oDat !== dataQ[0] || xDat !== dataQ[0]) begin
          errors++;
          $display("FAIL %s load-data beat %0d: got valid=%b data=%h other=%h, required valid=1 data=%h",
                   tag, beats, oVld, oDat, xDat, dataQ[0]);
        end
        checks++;
        if ({LoadDataReady, xVld, StoreDataValid} !== {rdy, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s load-ready: loadrdy/othervalid/storevalid=%b, required %b",
                   tag, {LoadDataReady, xVld, StoreDataValid}, {rdy, 2'b00});
        end
        if (LoadDataReady === 1'b1) begin
          void'(dataQ.pop_front());
          beats++;
        end
      end
      @(posedge Clock); #1;
    end
    Req0StoreValid = 1'b0; Req1StoreValid = 1'b0; StoreDataReady = 1'b0;
    LoadDataValid = 1'b0; Req0LoadReady = 1'b0; Req1LoadReady = 1'b0;
    checks++;
    if (beats != Chunks) begin
      errors++;
      $display("FAIL %s beats: got %0d, required %0d", tag, beats, Chunks);
    end
    checks++;
    if ({Busy, ProtocolError} !== 2'b00) begin
      errors++;
      $display("FAIL %s end-state: busy/protoerr=%b, required 00", tag, {Busy, ProtocolError});
    end
    if (cmdStall == 0 && !throttle) begin
      checks++;
      if (occ != 2 + Chunks) begin
        errors++;
        $display("FAIL %s occupancy: got %0d cycles, required %0d", tag, occ, 2 + Chunks);
      end
    end
    dataQ.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Req0CmdValid = 1'b1; Req1CmdValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({Req0CmdReady, Req1CmdReady, CmdOutValid, StoreDataValid, LoadDataReady, Req0StoreReady,
         Req1StoreReady, Req0LoadValid, Req1LoadValid, Busy, Owner, ProtocolError} !== 12'h000) begin
      errors++;
      $display("FAIL reset-outputs: got %b, required all 0", {Req0CmdReady, Req1CmdReady, CmdOutValid,
               StoreDataValid, LoadDataReady, Req0StoreReady, Req1StoreReady, Req0LoadValid,
               Req1LoadValid, Busy, Owner, ProtocolError});
    end
    checks++;
    if ({CmdOut, AddrOut, OldLeaf, NewLeaf} !== '0) begin
      errors++;
      $display("FAIL reset-fields: got %h, required 0", {CmdOut, AddrOut, OldLeaf, NewLeaf});
    end
    @(posedge Clock); #1;
    Req0CmdValid = 1'b0; Req1CmdValid = 1'b0; Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if ({Req0CmdReady, Req1CmdReady, CmdOutValid, Busy, Owner, ProtocolError} !== 6'b0) begin
      errors++;
      $display("FAIL reset-exit: got %b, required 000000",
               {Req0CmdReady, Req1CmdReady, CmdOutValid, Busy, Owner, ProtocolError});
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_read_rr();
    apply_reset();
    set_req(0, 1'b1, 2'd2, 32'd5, 10'd3, 10'd4);
    set_req(1, 1'b1, 2'd2, 32'd9, 10'd7, 10'd8);
    run_op(0, 2'd2, 32'd5, 10'd3, 10'd4, 0, 1'b0, 1'b1, 32'hA000_0000, "read-req0");
    run_op(1, 2'd2, 32'd9, 10'd7, 10'd8, 0, 1'b0, 1'b1, 32'hB000_0000, "read-req1");
  endtask

  task automatic test_append_stall();
    apply_reset();
    run_op(1, 2'd1, 32'd700, 10'd0, 10'h155, 10, 1'b0, 1'b1, 32'hC000_0000, "append-stall");
  endtask

  task automatic test_alternation();
    apply_reset();
    set_req(0, 1'b1, 2'd2, 32'd100, 10'd1, 10'd2);
    set_req(1, 1'b1, 2'd0, 32'd200, 10'd3, 10'd4);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        run_op(0, 2'd2, 32'(100 + k), 10'(k), 10'(k + 1), 0, 1'b0, 1'b0, 32'(32'h1000 * (k + 1)), "alternate");
      else
        run_op(1, 2'd0, 32'(200 + k), 10'(k), 10'(k + 2), 0, 1'b0, 1'b0, 32'(32'h1000 * (k + 1)), "alternate");
    end
  endtask

  task automatic test_protocol_error();
    apply_reset();
    @(negedge Clock);
    checks++;
    if ({ProtocolError, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL proto-before: protoerr/busy=%b, required 00", {ProtocolError, Busy});
    end
    @(posedge Clock); #1;
    LoadDataValid = 1'b1; LoadData = 32'hDEAD_BEEF; Req0LoadReady = 1'b1; Req1LoadReady = 1'b1;
    @(negedge Clock);
    checks++;
    if ({Req0LoadValid, Req1LoadValid, LoadDataReady} !== 3'b000) begin
      errors++;
      $display("FAIL proto-pulse: loadvalid0/1/loadrdy=%b, required 000", {Req0LoadValid, Req1LoadValid, LoadDataReady});
    end
    @(posedge Clock); #1;
    LoadDataValid = 1'b0; Req0LoadReady = 1'b0; Req1LoadReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      checks++;
      if ({ProtocolError, Busy, Req0LoadValid, Req1LoadValid} !== 4'b1000) begin
        errors++;
        $display("FAIL proto-sticky cycle %0d: protoerr/busy/lv0/lv1=%b, required 1000",
                 i, {ProtocolError, Busy, Req0LoadValid, Req1LoadValid});
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    int beats;
    bit granted;
    apply_reset();
    set_req(0, 1'b1, 2'd0, 32'd33, 10'd1, 10'd2);
    CmdOutReady = 1'b1; StoreDataReady = 1'b1; Req0StoreValid = 1'b1;
    beats = 0; granted = 1'b0;
    for (int cyc = 0; cyc < 60 && beats < 7; cyc++) begin
      Req0StoreData = 32'hD000 + 32'(beats);
      @(negedge Clock);
      if (Req0CmdReady === 1'b1) granted = 1'b1;
      if (StoreDataValid === 1'b1) begin
        checks++;
        if (StoreData !== 32'hD000 + 32'(beats)) begin
          errors++;
          $display("FAIL abort-data beat %0d: got %h, required %h", beats, StoreData, 32'hD000 + 32'(beats));
        end
        beats++;
      end
      @(posedge Clock); #1;
      if (granted) Req0CmdValid = 1'b0;
    end
    checks++;
    if (beats != 7) begin
      errors++;
      $display("FAIL abort-progress: got %0d beats before reset, required 7", beats);
    end
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({StoreDataValid, Req0StoreReady, CmdOutValid} !== 3'b000) begin
      errors++;
      $display("FAIL abort-during-reset: storevalid/storerdy/cmdvalid=%b, required 000",
               {StoreDataValid, Req0StoreReady, CmdOutValid});
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if ({Busy, StoreDataValid, Req0StoreReady, Owner} !== 4'b0000) begin
      errors++;
      $display("FAIL abort-after-reset: busy/storevalid/storerdy/owner=%b, required 0000",
               {Busy, StoreDataValid, Req0StoreReady, Owner});
    end
    @(posedge Clock); #1;
    Req0StoreValid = 1'b0; StoreDataReady = 1'b0; CmdOutReady = 1'b0;
    run_op(0, 2'd0, 32'd44, 10'd5, 10'd6, 0, 1'b0, 1'b1, 32'hE000_0000, "update-after-abort");
  endtask

  task automatic test_load_throttle();
    apply_reset();
    run_op(1, 2'd3, 32'd77, 10'h2AA, 10'h011, 0, 1'b1, 1'b1, 32'hF000_0000, "load-throttle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_rr();
    test_append_stall();
    test_alternation();
    test_protocol_error();
    test_reset_mid_store();
    test_load_throttle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
